// File: rtl/athena_ioctl_uploader_pkg.sv
// Shared types and constants for the ioctl upload responder and its window decoder.
package athena_upload_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUIESCE = 3'd1,
    READY   = 3'd2,
    FETCH   = 3'd3,
    DRAIN   = 3'd4
  } upload_state_t;

  localparam int LAT_W = 2;
  localparam logic [7:0] FF_FILL = 8'hFF;

endpackage

// File: rtl/athena_ioctl_uploader_if.sv
// hps_io ioctl upload bundle: hps_io is the master, the uploader is the slave.
// Handshake: ioctl_rd is a one-cycle strobe, legal only while ioctl_wait is low; the
// requested byte appears on ioctl_din in the cycle ioctl_wait falls again (or the cycle
// after the strobe when no wait is inserted), and holds until the next read completes.
interface athena_ioctl_uploader_if;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;

  modport master (output ioctl_upload, ioctl_rd, ioctl_addr, input ioctl_din, ioctl_wait);
  modport slave  (input ioctl_upload, ioctl_rd, ioctl_addr, output ioctl_din, ioctl_wait);
endinterface

// File: rtl/athena_ioctl_uploader_window.sv
// Combinational decode of an ioctl byte address into an in-window flag and RAM offset.
module athena_upload_window #(
  parameter logic [24:0] BASE_ADDR = 25'h0,
  parameter int          RAM_AW    = 11
) (
  input  logic [24:0]       addr,
  output logic              in_window,
  output logic [RAM_AW-1:0] offset
);
  logic [24:0] off;

  // Addresses below BASE_ADDR wrap to huge offsets; the explicit >= keeps them out.
  assign off       = addr - BASE_ADDR;
  assign offset    = off[RAM_AW-1:0];
  assign in_window = (addr >= BASE_ADDR) && ((off >> RAM_AW) == 25'd0);
endmodule

// File: rtl/athena_ioctl_uploader.sv
// Upload responder: freezes the CPUs and serves hps_io byte reads from a RAM window.
// Optional running checksum of delivered bytes: define ATHENA_UPLOAD_CHECKSUM_EN.
module athena_ioctl_uploader
  import athena_upload_pkg::*;
#(
  parameter logic [24:0] BASE_ADDR = 25'h0,
  parameter int          RAM_AW    = 11,
  parameter int          RD_LAT    = 2,
  parameter int          PAUSE_CYC = 8
) (
  input  logic                    i_clk,
  input  logic                    reset,
  athena_ioctl_uploader_if.slave  io,
  output logic [RAM_AW-1:0]       ram_addr,
  output logic                    ram_rd,
  input  logic [7:0]              ram_q,
  output logic                    pause_req,
  output logic                    busy,
  output logic [7:0]              checksum,
  output upload_state_t           dbg_state
);
  localparam int Q_W = $clog2(PAUSE_CYC + 1);

  upload_state_t     state;
  logic [Q_W-1:0]    qcnt;
  logic [LAT_W-1:0]  lcnt;
  logic [7:0]        din_r;
  logic              wait_r;
  logic              in_win;
  logic [RAM_AW-1:0] win_off;
  logic              capture;

  athena_upload_window #(.BASE_ADDR(BASE_ADDR), .RAM_AW(RAM_AW)) u_window (
    .addr      (io.ioctl_addr),
    .in_window (in_win),
    .offset    (win_off)
  );

  // ram_q is sampled on the RD_LAT-th edge after the strobe edge that launched ram_rd.
  assign capture       = (state == FETCH) && (lcnt == LAT_W'(1));
  assign io.ioctl_din  = din_r;
  assign io.ioctl_wait = wait_r;
  assign busy          = (state != IDLE);
  assign dbg_state     = state;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state     <= IDLE;
      qcnt      <= '0;
      lcnt      <= '0;
      din_r     <= FF_FILL;
      wait_r    <= 1'b0;
      ram_addr  <= '0;
      ram_rd    <= 1'b0;
      pause_req <= 1'b0;
    end else begin
      ram_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (io.ioctl_upload) begin
            state     <= QUIESCE;
            pause_req <= 1'b1;
            wait_r    <= 1'b1;
            qcnt      <= Q_W'(PAUSE_CYC - 1);
          end
        end
        QUIESCE: begin
          if (!io.ioctl_upload) begin
            state     <= IDLE;
            pause_req <= 1'b0;
            wait_r    <= 1'b0;
          end else if (qcnt == '0) begin
            state  <= READY;
            wait_r <= 1'b0;
          end else begin
            qcnt <= qcnt - Q_W'(1);
          end
        end
        READY: begin
          if (!io.ioctl_upload) begin
            state <= DRAIN;
          end else if (io.ioctl_rd) begin
            if (in_win) begin
              ram_addr <= win_off;
              ram_rd   <= 1'b1;
              wait_r   <= 1'b1;
              lcnt     <= LAT_W'(RD_LAT);
              state    <= FETCH;
            end else begin
              din_r <= FF_FILL;
            end
          end
        end
        FETCH: begin
          // Strobes arriving here violate the handshake and are dropped.
          if (capture) begin
            din_r  <= ram_q;
            wait_r <= 1'b0;
            state  <= io.ioctl_upload ? READY : DRAIN;
          end else begin
            lcnt <= lcnt - LAT_W'(1);
          end
        end
        DRAIN: begin
          state     <= IDLE;
          pause_req <= 1'b0;
          wait_r    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ATHENA_UPLOAD_CHECKSUM_EN
  logic [7:0] sum_r;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      sum_r <= 8'h00;
    end else if (state == IDLE && io.ioctl_upload) begin
      sum_r <= 8'h00;
    end else if (capture) begin
      sum_r <= sum_r + ram_q;
    end
  end

  assign checksum = sum_r;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_athena_ioctl_uploader.sv
// Directed bench for athena_ioctl_uploader with a byte scoreboard and a behavioural RAM.
module tb_athena_ioctl_uploader;
  import athena_upload_pkg::*;

  localparam logic [24:0] BASE   = 25'h1000;
  localparam int          AW     = 11;
  localparam int          LAT    = 2;
  localparam int          PCYC   = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [7:0]    ram_q = 8'h00;
  logic          pause_req;
  logic          busy;
  logic [7:0]    checksum;
  upload_state_t dbg_state;

  athena_ioctl_uploader_if ioctl ();

  athena_ioctl_uploader #(
    .BASE_ADDR(BASE), .RAM_AW(AW), .RD_LAT(LAT), .PAUSE_CYC(PCYC)
  ) dut (
    .i_clk     (clk),
    .reset     (reset),
    .io        (ioctl),
    .ram_addr  (ram_addr),
    .ram_rd    (ram_rd),
    .ram_q     (ram_q),
    .pause_req (pause_req),
    .busy      (busy),
    .checksum  (checksum),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural synchronous RAM
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (ram_rd) ram_q <= mem[ram_addr];

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] exp_sum;
  int checks = 0;
  int errors = 0;
  int rd_pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ram_rd) rd_pulses++;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_din"},      32'(ioctl.ioctl_din), 32'hFF);
    check({tag, "_wait"},     32'(ioctl.ioctl_wait), 0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 0);
    check({tag, "_ram_rd"},   32'(ram_rd), 0);
    check({tag, "_pause"},    32'(pause_req), 0);
    check({tag, "_busy"},     32'(busy), 0);
    check({tag, "_checksum"}, 32'(checksum), 0);
    check({tag, "_state"},    32'(dbg_state), 32'(IDLE));
  endtask

  task automatic expect_sum(input string tag);
`ifdef ATHENA_UPLOAD_CHECKSUM_EN
    check(tag, 32'(checksum), 32'(exp_sum));
`else
    check(tag, 32'(checksum), 0);
`endif
  endtask

  // One byte read; poke re-strobes ioctl_rd during the fetch (must be ignored).
  task automatic read_byte(input logic [24:0] addr, input bit poke);
    logic [24:0] off;
    bit          inw;
    logic [7:0]  e;
    int          p0;
    int          wc;
    off = addr - BASE;
    inw = (addr >= BASE) && (off < 25'(1 << AW));
    e   = inw ? mem[off[AW-1:0]] : 8'hFF;
    exp_q.push_back(e);
    if (inw) exp_sum = exp_sum + e;
    p0 = rd_pulses;
    ioctl.ioctl_addr = addr;
    ioctl.ioctl_rd   = 1'b1;
    tick();
    ioctl.ioctl_rd = 1'b0;
    if (inw) check("rd_ram_addr", 32'(ram_addr), 32'(off[AW-1:0]));
    wc = 0;
    for (int i = 0; i < 10; i++) begin
      if (poke && i == 0) begin
        ioctl.ioctl_addr = addr + 25'd1;
        ioctl.ioctl_rd   = 1'b1;
      end
      if (!ioctl.ioctl_wait) break;
      wc++;
      tick();
      ioctl.ioctl_rd = 1'b0;
    end
    check("rd_wait_cycles", 32'(wc), inw ? 32'(LAT) : 0);
    check("rd_data", 32'(ioctl.ioctl_din), 32'(exp_q.pop_front()));
    check("rd_ram_pulses", 32'(rd_pulses - p0), inw ? 1 : 0);
    check("rd_state", 32'(dbg_state), 32'(READY));
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (dbg_state != READY && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(dbg_state), 32'(READY));
  endtask

  initial begin
    int wc;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0]   = 8'h11;
    mem[1]   = 8'h80;
    mem[2]   = 8'h90;
    mem[3]   = 8'h10;
    mem[5]   = 8'hA5;
    mem[2047] = 8'h3C;
    exp_sum = 8'h00;

    reset = 1'b1;
    ioctl.ioctl_upload = 1'b0;
    ioctl.ioctl_rd     = 1'b0;
    ioctl.ioctl_addr   = '0;
    tick();
    tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();
    check_reset_vals("idle");

    // Session start with a simultaneous strobe that must be ignored.
    ioctl.ioctl_upload = 1'b1;
    ioctl.ioctl_rd     = 1'b1;
    ioctl.ioctl_addr   = 25'h1005;
    tick();
    ioctl.ioctl_rd = 1'b0;
    check("start_pause", 32'(pause_req), 1);
    check("start_busy", 32'(busy), 1);
    check("start_ram_rd", 32'(ram_rd), 0);
    check("start_state", 32'(dbg_state), 32'(QUIESCE));
    wc = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!ioctl.ioctl_wait) break;
      wc++;
    end
    check("quiesce_wait_len", 32'(wc), 32'(PCYC));
    check("quiesce_ready", 32'(dbg_state), 32'(READY));
    check("quiesce_no_ram_rd", 32'(rd_pulses), 0);

    read_byte(25'h1005, 1'b0);
    read_byte(25'h1800, 1'b0);
    read_byte(25'h1005, 1'b0);
    read_byte(25'h0FFF, 1'b0);
    read_byte(25'h17FF, 1'b0);
    read_byte(25'h1000, 1'b1);
    for (int i = 0; i < 4; i++)
      read_byte(BASE + 25'($urandom_range(0, (1 << AW) - 1)), 1'b0);
    read_byte(25'($urandom_range(25'h1800, 25'h1FFFF)), 1'b0);
    expect_sum("session1_checksum");

    // Upload drops during a fetch: byte still delivered, then one DRAIN cycle.
    exp_q.push_back(mem[5]);
    exp_sum = exp_sum + mem[5];
    ioctl.ioctl_addr = 25'h1005;
    ioctl.ioctl_rd   = 1'b1;
    tick();
    ioctl.ioctl_rd     = 1'b0;
    ioctl.ioctl_upload = 1'b0;
    tick();
    check("drop_fetch_wait", 32'(ioctl.ioctl_wait), 1);
    tick();
    check("drop_data", 32'(ioctl.ioctl_din), 32'(exp_q.pop_front()));
    check("drop_drain", 32'(dbg_state), 32'(DRAIN));
    check("drop_drain_pause", 32'(pause_req), 1);
    tick();
    check("drop_idle", 32'(dbg_state), 32'(IDLE));
    check("drop_pause", 32'(pause_req), 0);
    check("drop_busy", 32'(busy), 0);
    check("drop_wait", 32'(ioctl.ioctl_wait), 0);
    expect_sum("drop_checksum_hold");

    // Second session: wrapping checksum of 80+90+10.
    ioctl.ioctl_upload = 1'b1;
    exp_sum = 8'h00;
    tick();
    check("s2_checksum_clear", 32'(checksum), 0);
    wait_ready("s2_ready");
    read_byte(25'h1001, 1'b0);
    read_byte(25'h1002, 1'b0);
    read_byte(25'h1003, 1'b0);
`ifdef ATHENA_UPLOAD_CHECKSUM_EN
    check("s2_checksum_wrap", 32'(checksum), 32'h20);
`else
    check("s2_checksum_off", 32'(checksum), 0);
`endif

    // Reset mid-fetch: no late capture of ram_q.
    ioctl.ioctl_addr = 25'h1005;
    ioctl.ioctl_rd   = 1'b1;
    tick();
    ioctl.ioctl_rd = 1'b0;
    check("rst_fetch_state", 32'(dbg_state), 32'(FETCH));
    reset = 1'b1;
    ioctl.ioctl_upload = 1'b0;
    tick();
    check_reset_vals("rst_fetch");
    reset = 1'b0;
    tick();
    tick();
    tick();
    check("rst_after_din", 32'(ioctl.ioctl_din), 32'hFF);
    check("rst_after_state", 32'(dbg_state), 32'(IDLE));

    // Upload falling during QUIESCE returns to IDLE.
    ioctl.ioctl_upload = 1'b1;
    tick();
    tick();
    tick();
    ioctl.ioctl_upload = 1'b0;
    tick();
    check("qabort_state", 32'(dbg_state), 32'(IDLE));
    check("qabort_pause", 32'(pause_req), 0);
    check("qabort_wait", 32'(ioctl.ioctl_wait), 0);

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
